sincos_lut_engine: RTL and testbench

- Parametrised pipelined sine/cosine evaluator with a valid/ready handshake on both sides.
- Takes an unsigned fixed-point phase covering [0, 2π) plus a sine/cosine select.
- Returns the value as a sign/exponent/mantissa float, using a quarter-wave ROM with quadrant folding.
- Sits between the phase generator and the float arithmetic datapath; downstream backpressure stalls the whole pipe with no data loss.

---
 rtl/sincos_lut_engine.sv | 144 ++++++++++++++
 tb/tb_sincos_lut_engine.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sincos_lut_engine.sv
// Three-stage sine/cosine evaluator: phase fold, quarter-wave ROM read, sign apply.
// Produces a sign/exponent/mantissa float; one global advance enable stalls every stage together.
module sincos_lut_engine #(
    parameter int EXP_LEN      = 8,
    parameter int MANTISSA_LEN = 23,
    parameter int PHASE_W      = 16,
    parameter int LUT_ADDR_W   = 8,
    parameter int TAG_W        = 4,
    parameter     LUT_FILE     = "sine_quarter.hex"
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            inp_valid,
    output logic                            inp_ready,
    input  logic [PHASE_W-1:0]              inp_theta,
    input  logic                            inp_sine_cosine,
    input  logic [TAG_W-1:0]                inp_tag,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [EXP_LEN+MANTISSA_LEN:0]   out_value,
    output logic [TAG_W-1:0]                out_tag
);
    localparam int MAG_W  = EXP_LEN + MANTISSA_LEN;
    localparam int ADDR_W = LUT_ADDR_W + 1;
    localparam int DEPTH  = (1 << LUT_ADDR_W) + 1;
    localparam int BIAS   = (1 << (EXP_LEN - 1)) - 1;
    // pi in unsigned fixed point with 64 fraction bits
    localparam logic [131:0] PI_Q64 = 132'h3_243F_6A88_85A3_08D3;

    if (PHASE_W < LUT_ADDR_W + 2) begin : g_bad_params
        $error("sincos_lut_engine: PHASE_W must be at least LUT_ADDR_W+2");
    end

    // Quarter-wave entry k = sin(k*pi/2^(LUT_ADDR_W+1)) rounded to nearest, evaluated at elaboration.
    function automatic logic [MAG_W-1:0] sin_entry(input int k);
        logic [131:0]          x, x2, term, sum;
        logic [127:0]          norm;
        logic [MANTISSA_LEN:0] mant;
        logic                  guard, sticky;
        logic [MAG_W-1:0]      result;
        int                    lead, ex;
        x    = (PI_Q64 * 132'(k)) >> (LUT_ADDR_W + 1);
        x2   = (x * x) >> 64;
        term = x;
        sum  = x;
        for (int n = 1; n < 32; n++) begin
            term = ((term * x2) >> 64) / 132'((2 * n) * (2 * n + 1));
            if (n % 2 == 1) sum = sum - term;
            else            sum = sum + term;
        end
        lead = -1;
        for (int b = 0; b < 128; b++) begin
            if (sum[b]) lead = b;
        end
        result = '0;
        if (lead >= 0) begin
            norm   = sum[127:0] << (127 - lead);
            mant   = {1'b0, norm[126 -: MANTISSA_LEN]};
            guard  = norm[126 - MANTISSA_LEN];
            sticky = |(norm & ((128'd1 << (126 - MANTISSA_LEN)) - 128'd1));
            if (guard && (sticky || mant[0])) mant = mant + 1'b1;
            ex = lead - 64 + BIAS;
            if (mant[MANTISSA_LEN]) begin
                ex   = ex + 1;
                mant = '0;
            end
            result = {ex[EXP_LEN-1:0], mant[MANTISSA_LEN-1:0]};
        end
        return result;
    endfunction

    logic [MAG_W-1:0] rom [DEPTH];
    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam logic [MAG_W-1:0] ENTRY = sin_entry(k);
        assign rom[k] = ENTRY;
    end

    // Handshake: a sample moves in when inp_valid && inp_ready, out when out_valid && out_ready;
    // inp_ready mirrors the shared advance enable, gated off until the first edge after reset.
    logic ready_en;
    logic adv;
    logic take;

    assign adv       = !out_valid || out_ready;
    assign inp_ready = adv && ready_en;
    assign take      = inp_valid && inp_ready;

    logic [1:0]            quad;
    logic [LUT_ADDR_W-1:0] idx;
    logic [ADDR_W-1:0]     addr;

    // Adding a quarter turn only touches the top two phase bits, so the quadrant add is 2 bits wide.
    always_comb begin
        quad = inp_theta[PHASE_W-1 -: 2] + {1'b0, inp_sine_cosine};
        idx  = inp_theta[PHASE_W-3 -: LUT_ADDR_W];
        addr = {1'b0, idx};
        if (quad[0]) addr = ADDR_W'(DEPTH - 1) - {1'b0, idx};
    end

    logic              v1, v2;
    logic [ADDR_W-1:0] a1;
    logic              neg1, neg2;
    logic [TAG_W-1:0]  tag1, tag2;
    logic [MAG_W-1:0]  m2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en  <= 1'b0;
            v1        <= 1'b0;
            a1        <= '0;
            neg1      <= 1'b0;
            tag1      <= '0;
            v2        <= 1'b0;
            m2        <= '0;
            neg2      <= 1'b0;
            tag2      <= '0;
            out_valid <= 1'b0;
            out_value <= '0;
            out_tag   <= '0;
        end else begin
            ready_en <= 1'b1;
            if (adv) begin
                v1 <= take;
                if (take) begin
                    a1   <= addr;
                    neg1 <= quad[1];
                    tag1 <= inp_tag;
                end
                v2 <= v1;
                if (v1) begin
                    m2   <= rom[a1];
                    neg2 <= neg1;
                    tag2 <= tag1;
                end
                out_valid <= v2;
                if (v2) begin
                    // a zero magnitude always leaves with a clear sign bit
                    out_value <= {neg2 && (m2 != '0), m2};
                    out_tag   <= tag2;
                end
            end
        end
    end
endmodule

// File: tb/tb_sincos_lut_engine.sv
// Bench for sincos_lut_engine: vector table, backpressure, random handshake stress, mid-flight reset.
// Expected results come from a $sin-based float model and are queued on every input transfer.
module tb_sincos_lut_engine;
  localparam int TAG_W = 4;
  localparam int VAL_W = 32;
  localparam int QW = TAG_W + VAL_W;
  localparam real PI = 3.14159265358979323846;

  logic clk;
  logic rst;
  logic inp_valid;
  logic inp_ready;
  logic [15:0] inp_theta;
  logic inp_sine_cosine;
  logic [TAG_W-1:0] inp_tag;
  logic out_valid;
  logic out_ready;
  logic [VAL_W-1:0] out_value;
  logic [TAG_W-1:0] out_tag;

  sincos_lut_engine dut (
    .clk(clk),
    .rst(rst),
    .inp_valid(inp_valid),
    .inp_ready(inp_ready),
    .inp_theta(inp_theta),
    .inp_sine_cosine(inp_sine_cosine),
    .inp_tag(inp_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_value(out_value),
    .out_tag(out_tag)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_fail = 0;
  int n_out = 0;
  int cyc = 0;
  bit lat_on = 1'b0;
  logic [VAL_W-1:0] drv_exp = '0;
  logic [QW-1:0] exp_q[$];
  int t_q[$];
  bit stall_prev = 1'b0;
  logic [QW-1:0] held = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model
  function automatic logic [31:0] f32(input real r);
    logic [63:0] b;
    logic [52:0] m53;
    logic [24:0] m;
    logic g, st;
    int e;
    if (r == 0.0) return 32'h0;
    b = $realtobits(r);
    e = int'(b[62:52]) - 1023 + 127;
    m53 = {1'b1, b[51:0]};
    m = {1'b0, m53[52:29]};
    g = m53[28];
    st = |m53[27:0];
    if (g && (st || m[0])) m = m + 25'd1;
    if (m[24]) begin
      e = e + 1;
      m = m >> 1;
    end
    return {1'b0, e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] model(input logic [15:0] theta, input logic sc);
    logic [15:0] p;
    logic [1:0] q;
    logic [7:0] i;
    int a;
    logic [31:0] mag;
    p = theta + (sc ? 16'h4000 : 16'h0000);
    q = p[15:14];
    i = p[13:6];
    a = q[0] ? 256 - int'(i) : int'(i);
    mag = f32($sin(real'(a) * PI / 512.0));
    return (mag[30:0] == 31'h0) ? 32'h0 : {q[1], mag[30:0]};
  endfunction

  // driver
  task automatic send(input logic [15:0] th, input logic sc, input logic [3:0] tag,
                      input logic [31:0] ex);
    bit got;
    got = 1'b0;
    inp_valid = 1'b1;
    inp_theta = th;
    inp_sine_cosine = sc;
    inp_tag = tag;
    drv_exp = ex;
    for (int w = 0; w < 200 && !got; w++) begin
      @(negedge clk);
      got = inp_ready;
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: inp_ready stayed %b, expected 1 within 200 cycles", inp_ready);
    end
    @(posedge clk);
    #1;
    inp_valid = 1'b0;
    inp_theta = 16'($urandom);
    inp_sine_cosine = 1'($urandom_range(0, 1));
    inp_tag = 4'($urandom);
  endtask

  task automatic drain(input string name);
    for (int w = 0; w < 100 && exp_q.size() != 0; w++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    check(name, exp_q.size(), 0);
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    logic [QW-1:0] e;
    int t;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", {out_tag, out_value}, held);
      end
      if (out_valid && !out_ready) check("ready_in_stall", inp_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_output: got tag %h value %h, expected no output", out_tag, out_value);
        end else begin
          e = exp_q.pop_front();
          t = t_q.pop_front();
          check("result", {out_tag, out_value}, e);
          if (lat_on) check("latency", cyc - t, 3);
          n_out++;
        end
      end
      if (inp_valid && inp_ready) begin
        exp_q.push_back({inp_tag, drv_exp});
        t_q.push_back(cyc);
      end
      stall_prev = out_valid && !out_ready;
      held = {out_tag, out_value};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] theta;
    logic sc;
    logic [3:0] tag;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[14];

  initial begin
    logic [15:0] th;
    logic sc;
    vecs[0]  = '{16'h0000, 1'b0, 4'd0,  32'h0000_0000};
    vecs[1]  = '{16'h4000, 1'b0, 4'd1,  32'h3F80_0000};
    vecs[2]  = '{16'h8000, 1'b0, 4'd2,  32'h0000_0000};
    vecs[3]  = '{16'hC000, 1'b0, 4'd3,  32'hBF80_0000};
    vecs[4]  = '{16'h0000, 1'b1, 4'd4,  32'h3F80_0000};
    vecs[5]  = '{16'h4000, 1'b1, 4'd5,  32'h0000_0000};
    vecs[6]  = '{16'hC000, 1'b1, 4'd6,  32'h0000_0000};
    vecs[7]  = '{16'hFFFF, 1'b1, 4'd7,  model(16'hFFFF, 1'b1)};
    vecs[8]  = '{16'hFFFF, 1'b0, 4'd8,  model(16'hFFFF, 1'b0)};
    vecs[9]  = '{16'h2000, 1'b0, 4'd9,  32'h3F35_04F3};
    vecs[10] = '{16'hA000, 1'b0, 4'd10, 32'hBF35_04F3};
    vecs[11] = '{16'h6000, 1'b0, 4'd11, 32'h3F35_04F3};
    vecs[12] = '{16'h8000, 1'b1, 4'd12, 32'hBF80_0000};
    vecs[13] = '{16'h3FC0, 1'b0, 4'd13, model(16'h3FC0, 1'b0)};

    rst = 1'b1;
    out_ready = 1'b1;
    inp_valid = 1'b0;
    inp_theta = '0;
    inp_sine_cosine = 1'b0;
    inp_tag = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_value", out_value, 0);
    check("rst_out_tag", out_tag, 0);
    rst = 1'b0;
    check("ready_before_first_edge", inp_ready, 0);
    @(posedge clk);
    #1;
    check("ready_after_release", inp_ready, 1);

    // vector table, back-to-back with exact latency
    lat_on = 1'b1;
    n_out = 0;
    for (int k = 0; k < 14; k++) send(vecs[k].theta, vecs[k].sc, vecs[k].tag, vecs[k].exp);
    drain("table_drain");
    check("table_count", n_out, 14);

    // backpressure window
    lat_on = 1'b0;
    n_out = 0;
    fork
      begin
        for (int s = 0; s < 10; s++) begin
          th = 16'($urandom);
          sc = 1'($urandom_range(0, 1));
          send(th, sc, 4'(s), model(th, sc));
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("bp_drain");
    check("bp_count", n_out, 10);

    // random valid/ready stress
    n_out = 0;
    begin
      bit done;
      done = 1'b0;
      fork
        begin
          logic [15:0] rth;
          logic rsc;
          for (int s = 0; s < 2000; s++) begin
            if ($urandom_range(0, 3) == 0) begin
              repeat ($urandom_range(1, 3)) @(posedge clk);
              #1;
            end
            rth = 16'($urandom);
            rsc = 1'($urandom_range(0, 1));
            send(rth, rsc, 4'(s), model(rth, rsc));
          end
          done = 1'b1;
        end
        begin
          while (!done) begin
            @(posedge clk);
            #1 out_ready = ($urandom_range(0, 3) != 0);
          end
          out_ready = 1'b1;
        end
      join
    end
    drain("rand_drain");
    check("rand_count", n_out, 2000);

    // reset with three samples in flight
    n_out = 0;
    send(16'h1000, 1'b0, 4'd1, model(16'h1000, 1'b0));
    send(16'h5000, 1'b1, 4'd2, model(16'h5000, 1'b1));
    send(16'h9000, 1'b0, 4'd3, model(16'h9000, 1'b0));
    check("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("rst_async_valid", out_valid, 0);
    check("rst_async_value", out_value, 0);
    check("rst_async_tag", out_tag, 0);
    exp_q.delete();
    t_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("flushed_count", n_out, 0);
    lat_on = 1'b1;
    send(16'h4000, 1'b0, 4'd9, 32'h3F80_0000);
    drain("post_rst_drain");
    check("post_rst_count", n_out, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
